// File: rtl/button_debounce_pkg.sv
// btn_pkg: shared FSM state type and 25 MHz default timing for button debouncing
package btn_pkg;
    typedef enum logic [1:0] {
        REL_STABLE = 2'b00,
        REL_WAIT   = 2'b01,
        PRS_STABLE = 2'b10,
        PRS_WAIT   = 2'b11
    } btn_state_t;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_LONG_CYCLES     = 25000000;
    function automatic logic is_pressed(input btn_state_t s);
        return s == PRS_STABLE || s == PRS_WAIT;
    endfunction
endpackage

// File: rtl/button_debounce_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with a caller-chosen reset level
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rst_val,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= i_rst_val;
            r_q    <= i_rst_val;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end
    assign o_q = r_q;
endmodule

// File: rtl/button_debounce.sv
// button_debounce: debounced level, press/release pulses and optional long-press pulse
// Long-press detection is built only when BUTTON_DEBOUNCE_LONGPRESS_EN is defined.
module button_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW      = 1,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk25,
    input  logic fpga_rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);
    localparam int   CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic REL_PIN = (ACTIVE_LOW != 0);
    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_err
        $error("button_debounce: illegal DEBOUNCE_CYCLES/LONG_CYCLES");
    end
    logic          w_sync;
    logic          w_raw;
    logic          w_lvl_nxt;
    btn_state_t    r_state;
    btn_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    sync_2ff u_sync (
        .i_clk    (clk25),
        .i_rst    (fpga_rst),
        .i_rst_val(REL_PIN),
        .i_d      (btn_in),
        .o_q      (w_sync)
    );
    assign w_raw = w_sync ^ REL_PIN;
    // The counter only runs in the WAIT states and is zeroed on every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            REL_STABLE: w_state_nxt = w_raw ? REL_WAIT : REL_STABLE;
            PRS_STABLE: w_state_nxt = w_raw ? PRS_STABLE : PRS_WAIT;
            REL_WAIT: begin
                w_state_nxt = !w_raw ? REL_STABLE : (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) ? PRS_STABLE : REL_WAIT;
                w_cnt_nxt   = (w_state_nxt == REL_WAIT) ? r_cnt + CW'(1) : '0;
            end
            default: begin
                w_state_nxt = w_raw ? PRS_STABLE : (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) ? REL_STABLE : PRS_WAIT;
                w_cnt_nxt   = (w_state_nxt == PRS_WAIT) ? r_cnt + CW'(1) : '0;
            end
        endcase
    end
    assign w_lvl_nxt = is_pressed(w_state_nxt);
    always_ff @(posedge clk25) begin
        if (fpga_rst) begin
            r_state   <= REL_STABLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_lvl_nxt;
            r_press   <= w_lvl_nxt & ~r_level;
            r_release <= ~w_lvl_nxt & r_level;
        end
    end
    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam int HW = $clog2(LONG_CYCLES) + 1;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          r_long;
    // Hold count equals the number of cycles since btn_press, saturating at LONG_CYCLES.
    assign w_hold_nxt = (w_lvl_nxt != r_level) ? '0 :
                        (r_level && r_hold != HW'(LONG_CYCLES)) ? r_hold + HW'(1) : r_hold;
    always_ff @(posedge clk25) begin
        if (fpga_rst) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_hold <= w_hold_nxt;
            r_long <= (w_hold_nxt == HW'(LONG_CYCLES)) && (r_hold != HW'(LONG_CYCLES));
        end
    end
    assign btn_long = r_long;
`else
    assign btn_long = 1'b0;
`endif
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed and random stimulus against a sample-window reference model
module tb_button_debounce;
    localparam int D = 8;
    localparam int L = 32;
    logic clk25 = 1'b0;
    logic fpga_rst = 1'b1;
    logic btn_in = 1'b1;
    logic btn_level, btn_press, btn_release, btn_long;
    int checks = 0;
    int failures = 0;
    int n = 0;
    int press_n = -100000;
    bit exp_lvl, exp_prs, exp_rel, exp_lng;
    bit d0 = 1'b1, d1 = 1'b1;
    bit win[$];
    int seen_prs, seen_rel, seen_lng, cnt_prs, cnt_rel, cnt_lng;
    int t0;

    button_debounce #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .LONG_CYCLES(L)) dut (
        .clk25(clk25), .fpga_rst(fpga_rst), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_long(btn_long)
    );

    always #5 clk25 = ~clk25;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, n);
        end
    endtask

    task automatic clear_seen();
        seen_prs = -1; seen_rel = -1; seen_lng = -1;
        cnt_prs = 0; cnt_rel = 0; cnt_lng = 0;
    endtask

    // Level flips once the last D+1 synchronized samples all disagree with it.
    task automatic tick(input bit r, input bit p);
        bit raw, flip;
        fpga_rst = r;
        btn_in = p;
        @(posedge clk25);
        n++;
        exp_prs = 0; exp_rel = 0; exp_lng = 0;
        if (r) begin
            exp_lvl = 0; d0 = 1; d1 = 1;
            win.delete();
        end else begin
            raw = ~d1;
            d1 = d0;
            d0 = p;
            win.push_back(raw);
            if (win.size() > D + 1) void'(win.pop_front());
            flip = (win.size() == D + 1);
            foreach (win[i]) if (win[i] == exp_lvl) flip = 0;
            if (flip) begin
                exp_lvl = ~exp_lvl;
                if (exp_lvl) begin exp_prs = 1; press_n = n; end
                else exp_rel = 1;
                win.delete();
            end
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
            exp_lng = exp_lvl && (n - press_n == L);
`endif
        end
        #1;
        chk("level", btn_level, exp_lvl);
        chk("press", btn_press, exp_prs);
        chk("release", btn_release, exp_rel);
        chk("long", btn_long, exp_lng);
        if (btn_press === 1'b1) begin seen_prs = n; cnt_prs++; end
        if (btn_release === 1'b1) begin seen_rel = n; cnt_rel++; end
        if (btn_long === 1'b1) begin seen_lng = n; cnt_lng++; end
    endtask

    task automatic hold(input bit r, input bit p, input int cycles);
        for (int i = 0; i < cycles; i++) tick(r, p);
    endtask

    initial begin
        clear_seen();
        hold(1, 1, 5);
        hold(0, 1, 50);
        chk("idle_pulses", cnt_prs + cnt_rel + cnt_lng, 0);

        clear_seen();
        t0 = n + 1;
        hold(0, 0, 60);
        chk("press_latency", seen_prs, t0 + 10);
        chk("press_count", cnt_prs, 1);
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
        chk("long_latency", seen_lng, t0 + 10 + L);
        chk("long_count", cnt_lng, 1);
`else
        chk("long_count", cnt_lng, 0);
`endif
        t0 = n + 1;
        hold(0, 1, 30);
        chk("release_latency", seen_rel, t0 + 10);
        chk("release_count", cnt_rel, 1);

        clear_seen();
        for (int g = 0; g < 8; g++) begin
            hold(0, 0, 4);
            hold(0, 1, 1);
        end
        chk("glitch_no_press", cnt_prs, 0);
        t0 = n + 1;
        hold(0, 0, 20);
        chk("glitch_press_latency", seen_prs, t0 + 10);
        hold(0, 1, 20);

        clear_seen();
        hold(0, 0, 6);
        hold(1, 0, 3);
        chk("rst_wait_no_press", cnt_prs, 0);
        t0 = n + 1;
        hold(0, 0, 20);
        chk("rst_wait_press_latency", seen_prs, t0 + 10);

        clear_seen();
        hold(0, 0, 10);
        hold(1, 0, 2);
        chk("rst_hold_no_pulse", cnt_prs + cnt_rel + cnt_lng, 0);
        hold(1, 1, 2);
        hold(0, 1, 20);

        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 19) == 0) hold(1, 1'($urandom_range(0, 1)), 2);
            else hold(0, 1'($urandom_range(0, 1)), $urandom_range(1, 14));
        end
        hold(0, 0, 50);
        hold(0, 1, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable-input cycles required to accept a level change (20 ms at 25 MHz); legal range >= 2.
REQ-002 Parameter ACTIVE_LOW, default 1; 1 = pin low means pressed, 0 = pin high means pressed.
REQ-003 Parameter LONG_CYCLES, default 25000000; cycles pressed before a long-press event (1 s at 25 MHz); legal range > DEBOUNCE_CYCLES.
REQ-004 clk25  input  1  sole clock, 25 MHz system clock.
REQ-005 fpga_rst  input  1  synchronous, active-high reset.
REQ-006 btn_in  input  1  raw asynchronous button pin.
REQ-007 btn_level  output  1  debounced pressed state; 1 = pressed.
REQ-008 btn_press  output  1  one-cycle pulse when btn_level goes 0->1.
REQ-009 btn_release  output  1  one-cycle pulse when btn_level goes 1->0.
REQ-010 btn_long  output  1  one-cycle long-press pulse; see Configuration.

Function
REQ-011 btn_in SHALL pass through a 2-flop synchronizer; the synchronized value is inverted when ACTIVE_LOW=1, giving internal signal "raw_pressed".
REQ-012 FSM states SHALL be REL_STABLE, REL_WAIT, PRS_STABLE, PRS_WAIT.
REQ-013 REL_STABLE: raw_pressed=1 -> REL_WAIT, counter cleared to 0; otherwise stay.
REQ-014 REL_WAIT: raw_pressed=0 -> REL_STABLE, counter cleared (bounce rejected); otherwise counter increments; in the cycle the counter equals DEBOUNCE_CYCLES-1 -> PRS_STABLE.
REQ-015 PRS_STABLE and PRS_WAIT SHALL mirror REQ-013/014 with raw_pressed polarity inverted.
REQ-016 btn_level SHALL be registered, 1 exactly in PRS_STABLE and PRS_WAIT.
REQ-017 Latency: a clean pin edge SHALL change btn_level DEBOUNCE_CYCLES+2 cycles later (2 synchronizer cycles + DEBOUNCE_CYCLES).
REQ-018 btn_press/btn_release SHALL be registered and asserted in the same cycle btn_level first shows the new value, for exactly one cycle.
REQ-019 Any bounce shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no output change and no pulse.
REQ-020 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap, being cleared on every state transition.

Reset
REQ-021 While fpga_rst=1 at a clk25 edge: state REL_STABLE, counters 0, synchronizer flops at the "released" pin level, all outputs 0.
REQ-022 A button held through reset release SHALL be treated as a new press: btn_press fires DEBOUNCE_CYCLES+2 cycles after reset deasserts.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL abort without emitting any pulse.

Configuration
REQ-024 Macro BUTTON_DEBOUNCE_LONGPRESS_EN defined: a hold counter (width $clog2(LONG_CYCLES)+1) clears on btn_press, increments while btn_level=1, saturates; btn_long pulses one cycle when the count reaches LONG_CYCLES, at most once per press; btn_release clears the counter.
REQ-025 Macro undefined: hold counter absent, btn_long tied 0, LONG_CYCLES ignored.

Structure
REQ-026 Shared package btn_pkg SHALL hold the FSM state typedef (2-bit enum) and default timing constants for 25 MHz.
REQ-027 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value input), reusable on other GPIO inputs.

Verification (DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1)
REQ-028 Reset with btn_in=1 for 5 cycles, release -> all outputs 0, no pulses for 50 cycles.
REQ-029 btn_in 1->0 cleanly at cycle T -> btn_level=1 and btn_press=1 at T+10, btn_press=0 at T+11.
REQ-030 btn_in pressed, glitches high 1 cycle every 5 cycles for 40 cycles -> no btn_press; after glitches stop, btn_press 10 cycles after last edge.
REQ-031 Press held 60 cycles, then release -> btn_long single pulse 32 cycles after btn_press (macro on) or never (macro off); btn_release 10 cycles after pin edge; hold counter cleared.
REQ-032 Reset asserted at cycle 4 of REL_WAIT -> no btn_press; button still held -> btn_press 10 cycles after reset deasserts.
